des_block_loader: RTL
=====================

# des_block_loader

Input-side front end of the DES datapath, the counterpart to the output-side final permutation. Accepts plaintext/ciphertext as a byte stream with valid/ready flow control and assembles 8 bytes into a 64-bit block. Applies the DES initial permutation (IP) and presents the split halves L0/R0 to the round engine through a one-deep output register with valid/ready. An assembly buffer lets the next block load while the round engine stalls.

## Interface
- Parameters: none; the block width is fixed at 64 bits and 8 bytes per block.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- IN_DATA  in  8  byte of the input block, most-significant byte first.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- IN_DECRYPT  in  1  mode flag; sampled only on the first byte of a block.
- OUT_L0  out  32  IP output bits [63:32].
- OUT_R0  out  32  IP output bits [31:0].
- OUT_DECRYPT  out  1  mode flag carried with the block.
- OUT_VALID  out  1  OUT_L0/OUT_R0/OUT_DECRYPT are valid.
- OUT_READY  in  1  round engine accepts the block.

## Operation
- Transfers:
  - An input transfer occurs when IN_VALID && IN_READY.
  - An output transfer occurs when OUT_VALID && OUT_READY.
- Byte assembly:
  - A 3-bit beat counter (0..7) places byte n into asm[63-8n : 56-8n].
  - Beat 0 also latches IN_DECRYPT.
- Assembly states:
  - ASSEMBLE: accepting bytes; IN_READY=1.
  - FULL: 8 bytes held; IN_READY=0.
- Completing a block (input transfer with counter=7):
  - If the output register is empty, or an output transfer happens in the same cycle: load IP(asm with the last byte merged) and the mode flag into the output register, set OUT_VALID, return the counter to 0, stay in ASSEMBLE.
  - Otherwise: go to FULL, with the counter at 0.
- Leaving FULL: on the cycle the output register empties (an output transfer), load IP(asm) into it and return to ASSEMBLE. IN_READY stays 0 in that cycle and returns to 1 the cycle after.
- IP definition, for output bit m = 8a+b (a, b in 0..7): IP[m] = X[8(7-b) + j(a)].
  - j(a) = 2a+1 for a<4.
  - j(a) = 2(a-4) for a>=4.
  - X[63] is the first byte's MSB.
- The IP is the exact inverse of the final permutation, so final_permutation(IP(X)) = X.
- OUT_* hold stable while OUT_VALID=1 and OUT_READY=0.
- Reset mid-block: discards the partial block, any FULL block and the output register. Nothing is emitted.

## Timing
- Reset values:
  - IN_READY=1, OUT_VALID=0.
  - OUT_L0=0, OUT_R0=0, OUT_DECRYPT=0.
  - Counter=0, state=ASSEMBLE.
- Latency: the final byte accepted at edge N gives OUT_VALID=1 from edge N, visible in cycle N+1, when the output register is free.
- Throughput: one block per 8 cycles sustained, with IN_VALID and OUT_READY held at 1.
- IN_VALID gaps: the counter holds. There is no timeout.
- IN_READY is a registered state decode. It does not combinationally depend on OUT_READY.
- Simultaneous output transfer and block completion: the new block replaces the old one at the same edge. OUT_VALID stays 1 with no bubble.

## Structure
- Package des_pkg holds:
  - DES_BLOCK_W=64, DES_HALF_W=32, DES_BYTES=8.
  - The loader state enum (ASSEMBLE, FULL).
- Sub-module initial_permutation (combinational, DIN[63:0] -> DOUT[63:0]): instantiated once on the output-register load path and reusable elsewhere in the DES core.

## Test plan
- Bytes 01 23 45 67 89 AB CD EF, IN_DECRYPT=0, OUT_READY=1 -> OUT_L0=CC00CCFF, OUT_R0=F0AAF0AA, OUT_DECRYPT=0, OUT_VALID=1 in the cycle after the 8th byte.
- Block 00..00 then 00 00 00 00 00 00 00 01 -> first 00000000/00000000, then L0=00000080, R0=00000000. Every single-bit input X[i] yields exactly one bit set, matching the formula.
- OUT_READY=0 during two back-to-back blocks of FF bytes -> after the 2nd block IN_READY=0 (FULL). Raise OUT_READY -> both blocks delivered as FFFFFFFF/FFFFFFFF in order; IN_READY returns to 1 the cycle after the 2nd load.
- Random IN_VALID gaps and OUT_READY backpressure over 100 random blocks -> the scoreboard matches IP(X) and the mode flag; OUT_* stable while stalled.
- RST_N=0 after 5 bytes of a block, then a full fresh block of 01..EF -> only CC00CCFF/F0AAF0AA emitted; no stray output.
- IN_DECRYPT=1 on the first byte only, then toggled on bytes 2-8 -> OUT_DECRYPT=1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES datapath constants and the block loader state type.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_HALF_W  = 32;
  localparam int DES_BYTES   = 8;

  // ASSEMBLE: collecting bytes; FULL: a complete block waits for the output register.
  typedef enum logic {
    ASSEMBLE = 1'b0,
    FULL     = 1'b1
  } loader_state_e;

endpackage

// File: rtl/initial_permutation.sv
// DES initial permutation (IP), pure wiring.
// Output bit m = 8a+b takes input bit 8(7-b)+j(a), where j(a) walks the odd
// bit columns (1,3,5,7) for a<4 and then the even ones (0,2,4,6).
module initial_permutation
  import des_pkg::*;
(
  input  logic [DES_BLOCK_W-1:0] DIN,
  output logic [DES_BLOCK_W-1:0] DOUT
);

  for (genvar m = 0; m < DES_BLOCK_W; m++) begin : g_bit
    localparam int A   = m / 8;
    localparam int B   = m % 8;
    localparam int J   = (A < 4) ? (2 * A + 1) : (2 * (A - 4));
    localparam int SRC = 8 * (7 - B) + J;
    assign DOUT[m] = DIN[SRC];
  end

endmodule

// File: rtl/des_block_loader.sv
// DES input front end: assembles 8 bytes (MSB first) into a 64-bit block,
// applies the initial permutation and hands L0/R0 to the round engine through
// a one-deep valid/ready output register. A held block (FULL) lets the next
// block finish assembling while the round engine stalls.
module des_block_loader
  import des_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  IN_DECRYPT,
  output logic [DES_HALF_W-1:0] OUT_L0,
  output logic [DES_HALF_W-1:0] OUT_R0,
  output logic                  OUT_DECRYPT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  loader_state_e          state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DES_BLOCK_W-1:0] asm_q, asm_d;
  logic                   dec_asm_q, dec_asm_d;
  logic [DES_HALF_W-1:0]  l0_q, l0_d;
  logic [DES_HALF_W-1:0]  r0_q, r0_d;
  logic                   out_dec_q, out_dec_d;
  logic                   out_valid_q, out_valid_d;

  logic [DES_BLOCK_W-1:0] asm_merged;
  logic [DES_BLOCK_W-1:0] ip_in;
  logic [DES_BLOCK_W-1:0] ip_out;
  logic                   in_xfer;
  logic                   out_xfer;

  // Ready is a pure state decode so it never depends on OUT_READY.
  assign IN_READY = (state_q == ASSEMBLE);
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = out_valid_q && OUT_READY;

  // Current assembly buffer with the incoming byte dropped into its beat slot.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{~cnt_q, 3'b000} +: 8] = IN_DATA;
  end

  // A held block is permuted from the buffer; a completing block includes the last byte.
  assign ip_in = (state_q == FULL) ? asm_q : asm_merged;

  initial_permutation u_ip (
    .DIN  (ip_in),
    .DOUT (ip_out)
  );

  // Next-state, assembly and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    dec_asm_d   = dec_asm_q;
    l0_d        = l0_q;
    r0_d        = r0_q;
    out_dec_d   = out_dec_q;
    out_valid_d = out_valid_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ASSEMBLE: begin
        if (in_xfer) begin
          asm_d = asm_merged;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) begin
            dec_asm_d = IN_DECRYPT;
          end
          if (cnt_q == 3'd7) begin
            if (!out_valid_q || out_xfer) begin
              l0_d        = ip_out[63:32];
              r0_d        = ip_out[31:0];
              out_dec_d   = dec_asm_q;
              out_valid_d = 1'b1;
            end else begin
              state_d = FULL;
            end
          end
        end
      end
      FULL: begin
        if (out_xfer) begin
          l0_d        = ip_out[63:32];
          r0_d        = ip_out[31:0];
          out_dec_d   = dec_asm_q;
          out_valid_d = 1'b1;
          state_d     = ASSEMBLE;
        end
      end
      default: begin
        state_d = ASSEMBLE;
      end
    endcase
  end

  // Control state and the visible output register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ASSEMBLE;
      cnt_q       <= 3'd0;
      l0_q        <= '0;
      r0_q        <= '0;
      out_dec_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l0_q        <= l0_d;
      r0_q        <= r0_d;
      out_dec_q   <= out_dec_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Assembly buffer and its mode flag; contents are qualified by the counter and state.
  always_ff @(posedge CLK) begin
    asm_q     <= asm_d;
    dec_asm_q <= dec_asm_d;
  end

  assign OUT_L0      = l0_q;
  assign OUT_R0      = r0_q;
  assign OUT_DECRYPT = out_dec_q;
  assign OUT_VALID   = out_valid_q;

endmodule
